// File: rtl/sm3_sm4_link_pkg.sv
// Shared types and widths for the SM3-keyed SM4 sequencer.
// The word-counter width helper keeps a 1-bit counter for single-word messages.
package sm3_sm4_link_pkg;

    localparam int MSG_W = 32;
    localparam int BLK_W = 128;
    localparam int KEY_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HASH      = 3'd1,
        ST_HWAIT     = 3'd2,
        ST_KEYEXP    = 3'd3,
        ST_BLK_ISSUE = 3'd4,
        ST_BLK_WAIT  = 3'd5,
        ST_DONE      = 3'd6
    } link_state_e;

    function automatic int unsigned word_cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting on a core response.
// expired is high during the TIMEOUT-th enabled cycle after the last clear.
module link_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != TERM)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == TERM);

endmodule

// File: rtl/sm3_sm4_link_ctrl.sv
// Sequencer that hashes a message through SM3, uses the digest as the SM4 key,
// and streams blocks through SM4 one at a time with key reuse across jobs.
module sm3_sm4_link_ctrl
    import sm3_sm4_link_pkg::*;
#(
    parameter int unsigned MSG_WORDS  = 16,
    parameter logic [1:0]  LAST_BYTES = 2'b11,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rekey,
    input  logic             encdec_sel,
    input  logic [MSG_W-1:0] msg_word,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [BLK_W-1:0] blk_data,
    input  logic             blk_last,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic [BLK_W-1:0] res_data,
    output logic             res_valid,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             key_valid,
    output logic             sm3_en,
    output logic             sm3_msg_valid,
    output logic             sm3_last,
    output logic [MSG_W-1:0] sm3_msg,
    output logic [1:0]       sm3_last_bytes,
    input  logic [KEY_W-1:0] sm3_result,
    input  logic             sm3_finished,
    output logic             sm4_enable,
    output logic             sm4_encdec_enable,
    output logic             sm4_encdec_sel,
    output logic             sm4_key_exp_en,
    output logic             sm4_key_valid,
    output logic             sm4_valid,
    output logic [KEY_W-1:0] sm4_key,
    output logic [BLK_W-1:0] sm4_data,
    input  logic             sm4_key_ready,
    input  logic             sm4_ready,
    input  logic [BLK_W-1:0] sm4_result,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W = word_cnt_w(MSG_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_WORDS - 1);

    link_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             err_q, err_d;
    logic             kv_q, kv_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             msg_vld_q, msg_vld_d;
    logic             last_q, last_d;
    logic [1:0]       lb_q, lb_d;
    logic             kvp_q, kvp_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic             sv_q, sv_d;
    logic             blast_q, blast_d;
    logic [BLK_W-1:0] res_q, res_d;
    logic             rv_q, rv_d;
    logic             rl_q, rl_d;
    logic             done_q, done_d;

    logic wd_clear, wd_enable, wd_expired;

    // The watchdog restarts whenever the FSM changes state, so each wait
    // state sees a fresh count from its first cycle.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q == ST_HWAIT) || (state_q == ST_KEYEXP) ||
                       (state_q == ST_BLK_WAIT);

    link_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        err_d     = err_q;
        kv_d      = kv_q;
        key_d     = key_q;
        msg_d     = msg_q;
        msg_vld_d = 1'b0;
        last_d    = 1'b0;
        lb_d      = 2'b00;
        kvp_d     = 1'b0;
        data_d    = data_q;
        sv_d      = 1'b0;
        blast_d   = blast_q;
        res_d     = res_q;
        rv_d      = 1'b0;
        rl_d      = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = encdec_sel;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (rekey || !kv_q) ? ST_HASH : ST_BLK_ISSUE;
                end
            end
            ST_HASH: begin
                if (msg_valid) begin
                    msg_d     = msg_word;
                    msg_vld_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        last_d  = 1'b1;
                        lb_d    = LAST_BYTES;
                        cnt_d   = '0;
                        state_d = ST_HWAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HWAIT: begin
                if (sm3_finished) begin
                    key_d   = sm3_result;
                    kv_d    = 1'b1;
                    kvp_d   = 1'b1;
                    state_d = ST_KEYEXP;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (sm4_key_ready) begin
                    state_d = ST_BLK_ISSUE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_BLK_ISSUE: begin
                if (blk_valid) begin
                    data_d  = blk_data;
                    sv_d    = 1'b1;
                    blast_d = blk_last;
                    state_d = ST_BLK_WAIT;
                end
            end
            ST_BLK_WAIT: begin
                // sm4_ready is ignored during the sm4_valid cycle itself.
                if (sm4_ready && !sv_q) begin
                    res_d   = sm4_result;
                    rv_d    = 1'b1;
                    rl_d    = blast_q;
                    state_d = blast_q ? ST_DONE : ST_BLK_ISSUE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            err_q     <= 1'b0;
            kv_q      <= 1'b0;
            key_q     <= '0;
            msg_q     <= '0;
            msg_vld_q <= 1'b0;
            last_q    <= 1'b0;
            lb_q      <= 2'b00;
            kvp_q     <= 1'b0;
            data_q    <= '0;
            sv_q      <= 1'b0;
            blast_q   <= 1'b0;
            res_q     <= '0;
            rv_q      <= 1'b0;
            rl_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            kv_q      <= kv_d;
            key_q     <= key_d;
            msg_q     <= msg_d;
            msg_vld_q <= msg_vld_d;
            last_q    <= last_d;
            lb_q      <= lb_d;
            kvp_q     <= kvp_d;
            data_q    <= data_d;
            sv_q      <= sv_d;
            blast_q   <= blast_d;
            res_q     <= res_d;
            rv_q      <= rv_d;
            rl_q      <= rl_d;
            done_q    <= done_d;
        end
    end

    assign busy              = (state_q != ST_IDLE);
    assign msg_ready         = (state_q == ST_HASH);
    assign blk_ready         = (state_q == ST_BLK_ISSUE);
    assign sm4_key_exp_en    = (state_q == ST_KEYEXP);
    assign sm3_en            = busy;
    assign sm4_enable        = busy;
    assign sm4_encdec_enable = busy;
    assign sm4_encdec_sel    = sel_q;
    assign error             = err_q;
    assign key_valid         = kv_q;
    assign sm4_key           = key_q;
    assign sm4_key_valid     = kvp_q;
    assign sm3_msg           = msg_q;
    assign sm3_msg_valid     = msg_vld_q;
    assign sm3_last          = last_q;
    assign sm3_last_bytes    = lb_q;
    assign sm4_data          = data_q;
    assign sm4_valid         = sv_q;
    assign res_data          = res_q;
    assign res_valid         = rv_q;
    assign res_last          = rl_q;
    assign done              = done_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_sm3_sm4_link_ctrl.sv
// Directed bench for sm3_sm4_link_ctrl: the bench plays both cores and checks
// handshakes, key handling, watchdog and reset behaviour against hand values.
module tb_sm3_sm4_link_ctrl;

  localparam int MW = 16;
  localparam int TO = 8;
  localparam int W  = 129;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // res_valid is a one-cycle pulse with no backpressure.

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, rekey = 1'b0, encdec_sel = 1'b0;
  logic [31:0]  msg_word = '0;
  logic         msg_valid = 1'b0, msg_ready;
  logic [127:0] blk_data = '0;
  logic         blk_last = 1'b0, blk_valid = 1'b0, blk_ready;
  logic [127:0] res_data;
  logic         res_valid, res_last, busy, done, error, key_valid;
  logic         sm3_en, sm3_msg_valid, sm3_last;
  logic [31:0]  sm3_msg;
  logic [1:0]   sm3_last_bytes;
  logic [127:0] sm3_result = '0;
  logic         sm3_finished = 1'b0;
  logic         sm4_enable, sm4_encdec_enable, sm4_encdec_sel, sm4_key_exp_en;
  logic         sm4_key_valid, sm4_valid;
  logic [127:0] sm4_key, sm4_data;
  logic         sm4_key_ready = 1'b0, sm4_ready = 1'b0;
  logic [127:0] sm4_result = '0;
  logic [2:0]   dbg_state;

  sm3_sm4_link_ctrl #(.MSG_WORDS(MW), .LAST_BYTES(2'b11), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rekey(rekey), .encdec_sel(encdec_sel),
    .msg_word(msg_word), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .blk_data(blk_data), .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
    .busy(busy), .done(done), .error(error), .key_valid(key_valid),
    .sm3_en(sm3_en), .sm3_msg_valid(sm3_msg_valid), .sm3_last(sm3_last),
    .sm3_msg(sm3_msg), .sm3_last_bytes(sm3_last_bytes), .sm3_result(sm3_result),
    .sm3_finished(sm3_finished), .sm4_enable(sm4_enable), .sm4_encdec_enable(sm4_encdec_enable),
    .sm4_encdec_sel(sm4_encdec_sel), .sm4_key_exp_en(sm4_key_exp_en),
    .sm4_key_valid(sm4_key_valid), .sm4_valid(sm4_valid), .sm4_key(sm4_key),
    .sm4_data(sm4_data), .sm4_key_ready(sm4_key_ready), .sm4_ready(sm4_ready),
    .sm4_result(sm4_result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int res_cnt = 0, rlast_cnt = 0, done_cnt = 0, kvp_cnt = 0, mrdy_cnt = 0, words = 0;
  logic [31:0]  exp_last_word = '0;
  logic [127:0] cur_key = '0;
  logic         cur_sel = 1'b0;

  typedef struct {
    logic         rekey;
    logic         sel;
    logic         exp_hash;
    logic [31:0]  last_word;
    logic [127:0] digest;
    logic [127:0] block;
    logic [127:0] result;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] outs_or();
    return res_data | sm4_key | sm4_data | 128'(sm3_msg) |
           128'({msg_ready, blk_ready, res_valid, res_last, busy, done, error, key_valid,
                 sm3_en, sm3_msg_valid, sm3_last, sm3_last_bytes, sm4_enable,
                 sm4_encdec_enable, sm4_encdec_sel, sm4_key_exp_en, sm4_key_valid,
                 sm4_valid, dbg_state});
  endfunction

  // Monitor: results against the expected queue, plus event counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid) begin
        res_cnt++;
        if (res_last) rlast_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_res_valid", {res_last, res_data}, '0);
        end else begin
          check("res_data_last", {res_last, res_data}, exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
      if (sm4_key_valid) kvp_cnt++;
      if (msg_ready) mrdy_cnt++;
      if (sm3_msg_valid) begin
        words++;
        check("sm3_last_flags", W'({sm3_last, sm3_last_bytes}),
              (words % MW == 0) ? W'(3'b111) : W'(0));
        check("sm3_msg", W'(sm3_msg), (words % MW == 0) ? W'(exp_last_word) : W'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 60) begin
      tick(1);
      cyc++;
    end
    check("wait_idle", W'(busy), W'(0));
  endtask

  task automatic do_start(input logic r, input logic s);
    start = 1'b1; rekey = r; encdec_sel = s;
    tick(1);
    start = 1'b0; rekey = 1'b0; encdec_sel = 1'b0;
    cur_sel = s;
    check("busy_after_start", W'(busy), W'(1));
    check("error_clear_on_start", W'(error), W'(0));
    check("encdec_sel_latched", W'(sm4_encdec_sel), W'(s));
  endtask

  task automatic send_msg(input logic [31:0] lw, input bit gaps);
    int sent = 0;
    int cyc = 0;
    logic ok;
    exp_last_word = lw;
    while (sent < MW && cyc < 400) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        msg_valid = 1'b0;
      end else begin
        msg_valid = 1'b1;
        msg_word = (sent == MW - 1) ? lw : 32'h0;
      end
      ok = msg_ready;
      tick(1);
      cyc++;
      if (msg_valid && ok) sent++;
    end
    msg_valid = 1'b0;
    msg_word = '0;
    check("msg_words_sent", W'(sent), W'(MW));
  endtask

  task automatic finish_hash(input logic [127:0] dg);
    tick(2);
    sm3_result = dg;
    sm3_finished = 1'b1;
    tick(1);
    sm3_finished = 1'b0;
    cur_key = dg;
    check("key_valid_after_finish", W'(key_valid), W'(1));
    check("sm4_key_valid_pulse", W'(sm4_key_valid), W'(1));
    check("sm4_key", W'(sm4_key), W'(dg));
    tick(1);
    check("sm4_key_valid_one_cycle", W'({sm4_key_valid, sm4_key_exp_en}), W'(2'b01));
    sm4_key_ready = 1'b1;
    tick(1);
    sm4_key_ready = 1'b0;
    check("blk_ready_after_keyexp", W'(blk_ready), W'(1));
  endtask

  task automatic send_block(input logic [127:0] b, input logic l, input bit gaps);
    int cyc = 0;
    bit acc = 0;
    logic ok;
    while (!acc && cyc < 100) begin
      blk_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      blk_data = b;
      blk_last = l;
      ok = blk_ready;
      tick(1);
      cyc++;
      if (blk_valid && ok) acc = 1;
    end
    blk_valid = 1'b0;
    blk_last = 1'b0;
    check("blk_accepted", W'(acc), W'(1));
    check("sm4_valid_pulse", W'(sm4_valid), W'(1));
    check("sm4_data", W'(sm4_data), W'(b));
    check("sm4_key_in_use", W'(sm4_key), W'(cur_key));
    check("sm4_levels", W'({sm4_enable, sm4_encdec_enable, sm3_en, sm4_encdec_sel}),
          W'({3'b111, cur_sel}));
  endtask

  task automatic respond_sm4(input logic [127:0] r, input logic l, input int dly);
    exp_q.push_back({l, r});
    tick(dly);
    sm4_result = r;
    sm4_ready = 1'b1;
    tick(1);
    sm4_ready = 1'b0;
    check("res_valid_after_ready", W'(res_valid), W'(1));
  endtask

  task automatic run_job(input vec_t v);
    int k0, m0, d0;
    wait_idle();
    k0 = kvp_cnt; m0 = mrdy_cnt; d0 = done_cnt;
    do_start(v.rekey, v.sel);
    check("msg_ready_after_start", W'(msg_ready), W'(v.exp_hash));
    check("blk_ready_after_start", W'(blk_ready), W'(!v.exp_hash));
    if (v.exp_hash) begin
      send_msg(v.last_word, 1'b0);
      finish_hash(v.digest);
    end
    send_block(v.block, 1'b1, 1'b0);
    respond_sm4(v.result, 1'b1, 3);
    check("done_before_time", W'(done), W'(0));
    tick(1);
    check("done_pulse", W'({done, busy}), W'(2'b10));
    check("job_key_pulses", W'(kvp_cnt - k0), W'(v.exp_hash));
    check("job_msg_ready_cycles", W'(mrdy_cnt - m0), v.exp_hash ? W'(MW) : W'(0));
    tick(1);
    check("job_done_count", W'(done_cnt - d0), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, l0, d0;
    logic [127:0] mb_blk[3];
    logic [127:0] mb_res[3];

    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h61626364, 128'h0123456789abcdeffedcba9876543210,
                128'h0123456789abcdeffedcba9876543210, 128'h681edf34d206965e86b3e94f536e4246};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 128'h0,
                128'h681edf34d206965e86b3e94f536e4246, 128'h0123456789abcdeffedcba9876543210};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h11223344, 128'h00112233445566778899aabbccddeeff,
                128'hdeadbeef00000000111111112222222f, 128'hcafef00d0123456789abcdef55aa55aa};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h61626364, 128'h0123456789abcdeffedcba9876543210,
                128'h0123456789abcdeffedcba9876543210, 128'h681edf34d206965e86b3e94f536e4246};
    mb_blk[0] = 128'h1; mb_blk[1] = 128'h2; mb_blk[2] = 128'h3;
    mb_res[0] = 128'hAAAA; mb_res[1] = 128'hBBBB; mb_res[2] = 128'hCCCC;

    // Reset state
    tick(3);
    check("reset_outputs_zero_in_reset", W'(outs_or()), W'(0));
    reset = 1'b0;
    tick(1);
    check("reset_outputs_zero", W'(outs_or()), W'(0));

    // Table-driven single-block jobs
    for (int i = 0; i < 3; i++) run_job(vecs[i]);

    // Multi-block with msg/blk stalls and a start pulse while busy
    wait_idle();
    r0 = res_cnt; l0 = rlast_cnt; d0 = done_cnt;
    do_start(1'b1, 1'b0);
    send_msg(32'h55aa55aa, 1'b1);
    finish_hash(128'hfeedfacefeedfacefeedfacefeedface);
    for (int b = 0; b < 3; b++) begin
      send_block(mb_blk[b], (b == 2), 1'b1);
      if (b == 1) begin
        start = 1'b1; rekey = 1'b1;
        tick(1);
        start = 1'b0; rekey = 1'b0;
        check("start_ignored_busy", W'({msg_ready, busy}), W'(2'b01));
        respond_sm4(mb_res[b], 1'b0, 2);
      end else begin
        respond_sm4(mb_res[b], (b == 2), 2);
      end
    end
    tick(3);
    check("mb_res_count", W'(res_cnt - r0), W'(3));
    check("mb_last_count", W'(rlast_cnt - l0), W'(1));
    check("mb_done_count", W'(done_cnt - d0), W'(1));

    // Watchdog timeout in HWAIT
    wait_idle();
    d0 = done_cnt;
    do_start(1'b1, 1'b0);
    send_msg(32'h0badf00d, 1'b0);
    tick(TO - 1);
    check("hwait_before_timeout", W'({error, busy, key_valid}), W'(3'b011));
    tick(1);
    check("timeout_flags", W'({error, key_valid, busy}), W'(3'b100));
    tick(2);
    check("error_sticky", W'(error), W'(1));
    check("timeout_no_done", W'(done_cnt - d0), W'(0));
    run_job(vecs[3]);

    // sm4_ready on the watchdog terminal cycle: the response wins
    wait_idle();
    do_start(1'b0, 1'b0);
    check("reuse_blk_ready", W'(blk_ready), W'(1));
    send_block(128'h5555, 1'b1, 1'b0);
    tick(TO - 2);
    check("blk_wait_alive", W'({busy, error}), W'(2'b10));
    respond_sm4(128'h7777, 1'b1, 1);
    check("race_no_error", W'({error, key_valid}), W'(2'b01));
    tick(1);
    check("race_done", W'({done, error}), W'(2'b10));

    // Reset in BLK_WAIT, then a late sm4_ready
    wait_idle();
    do_start(1'b0, 1'b1);
    send_block(128'h9999, 1'b1, 1'b0);
    tick(2);
    r0 = res_cnt; d0 = done_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midjob_reset_zero", W'(outs_or()), W'(0));
    sm4_result = 128'h1234;
    sm4_ready = 1'b1;
    tick(1);
    sm4_ready = 1'b0;
    tick(2);
    check("late_ready_ignored", W'(res_cnt - r0), W'(0));
    check("reset_no_done", W'(done_cnt - d0), W'(0));
    check("exp_q_drained", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL global_time_limit: simulation exceeded bound at t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
